// File: rtl/uart_irq_pkg.sv
// Shared constants and FSM state type for the UART interrupt controller.
// Register addresses, status bit positions and controller states.
package uart_irq_pkg;

  localparam logic [1:0] ADDR_PEND = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_RAW  = 2'd2;
  localparam logic [1:0] ADDR_ID   = 2'd3;

  localparam int FE   = 0;
  localparam int CRCE = 1;
  localparam int ORE  = 2;
  localparam int NF   = 3;
  localparam int TXI  = 4;
  localparam int TBNF = 5;
  localparam int DR   = 6;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    SERVICE,
    HOLDOFF
  } state_t;

endpackage

// File: rtl/uart_irq_prio.sv
// Lowest-index-wins 8-to-3 priority encoder.
// valid is high when any request bit is set.
module uart_irq_prio (
  input  logic [7:0] req,
  output logic [2:0] id,
  output logic       valid
);

  always_comb begin
    id = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) id = 3'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/uart_irq_ctrl.sv
// UART status edge-to-pending latch, mask, irq FSM and CPU registers.
// Define UART_IRQ_HOLDOFF_EN to add a minimum irq-low time after service.
module uart_irq_ctrl
  import uart_irq_pkg::*;
#(
  parameter int NSRC           = 7,
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] stat_in,
  input  logic       cpu_rd,
  input  logic       cpu_wr,
  input  logic [1:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_rvalid,
  output logic       irq,
  output logic [2:0] irq_id
);

  localparam logic [7:0] SRC_MASK =
    8'((9'd1 << NSRC) - 9'd1);

  logic [7:0] stat_q;
  logic [7:0] pend;
  logic [7:0] mask;
  logic [7:0] rise;
  logic [7:0] clr;
  logic [7:0] act_vec;
  logic [7:0] rd_mux;
  logic [2:0] enc_id;
  logic       act;
  logic       wr_pend;
  logic       rd_id;
  state_t     state;

`ifdef UART_IRQ_HOLDOFF_EN
  localparam int CW = $clog2(HOLDOFF_CYCLES) + 1;
  logic [CW-1:0] hcnt;
`endif

  assign rise    = stat_in & ~stat_q & SRC_MASK;
  assign wr_pend = cpu_wr && (cpu_addr == ADDR_PEND);
  assign rd_id   = cpu_rd && (cpu_addr == ADDR_ID);
  assign clr     = wr_pend ? cpu_wdata : 8'h00;
  assign act_vec = pend & mask;

  uart_irq_prio u_prio (
    .req   (act_vec),
    .id    (enc_id),
    .valid (act)
  );

  always_comb begin
    rd_mux = 8'h00;
    unique case (cpu_addr)
      ADDR_PEND: rd_mux = pend;
      ADDR_MASK: rd_mux = mask;
      ADDR_RAW:  rd_mux = stat_in & SRC_MASK;
      ADDR_ID:   rd_mux = {act, 4'b0000, irq_id};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_q     <= 8'h00;
      pend       <= 8'h00;
      mask       <= 8'h00;
      cpu_rdata  <= 8'h00;
      cpu_rvalid <= 1'b0;
      irq_id     <= 3'd0;
    end else begin
      stat_q     <= stat_in;
      // a new rising edge wins over a same-cycle clear
      pend       <= (pend & ~clr) | rise;
      irq_id     <= enc_id;
      cpu_rvalid <= cpu_rd;
      if (cpu_rd) cpu_rdata <= rd_mux;
      if (cpu_wr && (cpu_addr == ADDR_MASK))
        mask <= cpu_wdata & SRC_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      irq   <= 1'b0;
`ifdef UART_IRQ_HOLDOFF_EN
      hcnt  <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (act) begin
            state <= ASSERT;
            irq   <= 1'b1;
          end
        end
        ASSERT: begin
          if (!act) begin
            state <= IDLE;
            irq   <= 1'b0;
          end else if (rd_id) begin
            state <= SERVICE;
            irq   <= 1'b0;
          end
        end
        SERVICE: begin
          irq <= 1'b0;
          if (wr_pend) begin
`ifdef UART_IRQ_HOLDOFF_EN
            state <= HOLDOFF;
            hcnt  <= CW'(HOLDOFF_CYCLES - 1);
`else
            state <= IDLE;
`endif
          end
        end
        HOLDOFF: begin
          irq <= 1'b0;
`ifdef UART_IRQ_HOLDOFF_EN
          if (hcnt == '0) state <= IDLE;
          else            hcnt  <= hcnt - 1'b1;
`else
          state <= IDLE;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// Scoreboard bench for uart_irq_ctrl: reads queue expected data,
// a negedge monitor pops on cpu_rvalid; irq checks are directed.
module tb_uart_irq_ctrl;
  import uart_irq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] stat_in;
  logic       cpu_rd;
  logic       cpu_wr;
  logic [1:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_rvalid;
  logic       irq;
  logic [2:0] irq_id;

  int checks = 0;
  int failures = 0;
  logic [7:0] expq[$];
  string      nameq[$];
  bit         done = 1'b0;

  uart_irq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .stat_in    (stat_in),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .irq        (irq),
    .irq_id     (irq_id)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!done && cpu_rvalid) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rvalid rdata=%h", cpu_rdata);
      end else begin
        logic [7:0] e;
        string n;
        e = expq.pop_front();
        n = nameq.pop_front();
        if (cpu_rdata !== e) begin
          failures++;
          $display("FAIL %s got=%h exp=%h", n, cpu_rdata, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string n, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  task automatic acc(bit r, bit w, logic [1:0] a,
                     logic [7:0] d, logic [7:0] e, string n);
    cpu_rd    = r;
    cpu_wr    = w;
    cpu_addr  = a;
    cpu_wdata = d;
    if (r) begin
      expq.push_back(e);
      nameq.push_back(n);
    end
    cyc();
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  task automatic rd(logic [1:0] a, logic [7:0] e, string n);
    acc(1'b1, 1'b0, a, 8'h00, e, n);
  endtask

  task automatic wr(logic [1:0] a, logic [7:0] d);
    acc(1'b0, 1'b1, a, d, 8'h00, "");
  endtask

  initial begin
    reset = 1'b1; stat_in = 8'h40;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    cpu_addr = 2'd0; cpu_wdata = 8'h00;
    repeat (3) cyc();
    chk("rst_irq", {7'd0, irq}, 8'h00);
    chk("rst_rvalid", {7'd0, cpu_rvalid}, 8'h00);
    chk("rst_rdata", cpu_rdata, 8'h00);
    chk("rst_id", {5'd0, irq_id}, 8'h00);
    reset = 1'b0;
    cyc();
    rd(ADDR_PEND, 8'h40, "t1_pend");
    rd(ADDR_MASK, 8'h00, "t1_mask");
    rd(ADDR_ID, 8'h00, "t1_id");
    chk("t1_irq", {7'd0, irq}, 8'h00);
    wr(ADDR_PEND, 8'h40);
    wr(ADDR_MASK, 8'hFF);
    rd(ADDR_MASK, 8'h7F, "mask_bit7");
    wr(ADDR_MASK, 8'h7F);
    rd(ADDR_PEND, 8'h00, "w1c_pend");

    stat_in = 8'h04;
    cyc();
    chk("t2_irq_early", {7'd0, irq}, 8'h00);
    stat_in = 8'h00;
    cyc();
    chk("t2_irq_high", {7'd0, irq}, 8'h01);
    rd(ADDR_ID, 8'h82, "t2_id");
    chk("t2_irq_drop", {7'd0, irq}, 8'h00);
    cyc();
    chk("t2_rvalid_pulse", {7'd0, cpu_rvalid}, 8'h00);
    chk("t2_rdata_hold", cpu_rdata, 8'h82);
    wr(ADDR_PEND, 8'h04);
    cyc();
    chk("t2_idle", {7'd0, irq}, 8'h00);

    stat_in = 8'h42;
    cyc();
    stat_in = 8'h00;
    cyc();
    chk("t3_irq", {7'd0, irq}, 8'h01);
    rd(ADDR_ID, 8'h81, "t3_id1");
    wr(ADDR_PEND, 8'h02);
    cyc();
    chk("t3_reassert", {7'd0, irq}, 8'h01);
    rd(ADDR_ID, 8'h86, "t3_id6");
    rd(ADDR_PEND, 8'h40, "t3_pend");

    stat_in = 8'h40;
    wr(ADDR_PEND, 8'h40);
    stat_in = 8'h00;
    rd(ADDR_PEND, 8'h40, "t4_set_wins");
    cyc();
    chk("t5_irq", {7'd0, irq}, 8'h01);
    wr(ADDR_MASK, 8'h3F);
    cyc();
    chk("t5_masked", {7'd0, irq}, 8'h00);
    rd(ADDR_PEND, 8'h40, "t5_pend_kept");
    rd(ADDR_ID, 8'h00, "t5_id_none");
    wr(ADDR_MASK, 8'h7F);
    cyc();
    chk("t5_unmask", {7'd0, irq}, 8'h01);

    wr(ADDR_ID, 8'hFF);
    wr(ADDR_RAW, 8'hFF);
    rd(ADDR_PEND, 8'h40, "ro_ignored");
    stat_in = 8'hC5;
    rd(ADDR_RAW, 8'h45, "raw");
    acc(1'b1, 1'b1, ADDR_PEND, 8'hFF, 8'h45, "rdwr_prewrite");
    rd(ADDR_PEND, 8'h00, "rdwr_cleared");

`ifdef UART_IRQ_HOLDOFF_EN
    stat_in = 8'h00;
    repeat (3) cyc();
    stat_in = 8'h08;
    cyc();
    stat_in = 8'h00;
    cyc();
    rd(ADDR_ID, 8'h83, "t6_id");
    stat_in = 8'h10;
    wr(ADDR_PEND, 8'h08);
    for (int i = 0; i < 4; i++) begin
      chk("t6_holdoff_low", {7'd0, irq}, 8'h00);
      cyc();
    end
    begin
      int n;
      n = 0;
      while (!irq && n < 8) begin
        cyc();
        n++;
      end
      chk("t6_reassert", {7'd0, irq}, 8'h01);
    end
`endif

    repeat (2) cyc();
    chk("queue_empty", 8'(expq.size()), 8'h00);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/uart_irq_ctrl.md
Name: uart_irq_ctrl

Overview:
CPU-side reader for the UART status/interrupt register. Turns the 8-bit status flags driven by the UART into sticky pending bits on rising edges. Applies a mask and raises one registered interrupt line. Gives the CPU a small 4-address register file with read data, write-1-to-clear acknowledge and a priority-encoded source ID. Sits between the UART status register output and the CPU bus.

Parameters:
NSRC, 7, number of live sources (bits 0..NSRC-1); higher bits read as 0
HOLDOFF_CYCLES, 4, minimum irq low time after service (used only with the optional feature)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
stat_in  in  8  live status flags: 0 fe, 1 crce, 2 ore, 3 nf, 4 txi, 5 tbnf, 6 dr, 7 reserved
cpu_rd  in  1  read strobe, one cycle per access
cpu_wr  in  1  write strobe, one cycle per access
cpu_addr  in  2  0 PEND, 1 MASK, 2 RAW, 3 ID
cpu_wdata  in  8  write data
cpu_rdata  out  8  read data, registered
cpu_rvalid  out  1  high for one cycle, one cycle after cpu_rd
irq  out  1  registered interrupt request to CPU
irq_id  out  3  index of highest-priority enabled pending source

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset. On reset, all of the following go to 0: pend, mask, stat_q, cpu_rdata, cpu_rvalid, irq, irq_id and the holdoff counter. FSM goes to IDLE.
- Edge detect:
  - stat_q <= stat_in every cycle.
  - rise = stat_in & ~stat_q, with bits >= NSRC forced to 0.
  - After reset, stat_q = 0, so any flag already high sets pending on the first cycle.
- Pending update: pend <= (pend & ~clr) | rise.
  - clr = cpu_wdata when cpu_wr and cpu_addr = 0; otherwise 0.
  - Set wins over clear in the same cycle.
- MASK: written on cpu_wr with cpu_addr = 1; bits >= NSRC stored as 0.
- RAW and ID are read-only; writes to addresses 2 and 3 are ignored.
- Reads:
  - cpu_rd samples the address; the cycle after, cpu_rdata holds the register value and cpu_rvalid = 1.
  - cpu_rdata holds its value until the next read.
  - ID read returns {valid, 4'b0, irq_id}, where valid = |(pend & mask).
  - cpu_rd and cpu_wr in the same cycle: write applies, and the read returns the pre-write value.
- Priority: lowest index wins (errors before txi/tbnf/dr). irq_id is registered; it is 0 when nothing is enabled and pending.
- FSM (act = |(pend & mask)):
  - IDLE: irq = 0. If act, go to ASSERT (irq goes high in the next cycle; 1 cycle after pend & mask becomes nonzero).
  - ASSERT: irq = 1. A CPU read of ID moves to SERVICE. If act drops (mask or clear), return to IDLE.
  - SERVICE: irq = 0. A write to PEND returns to IDLE, where act is re-evaluated (re-assert is allowed on the next cycle).
  - Reset in any state goes to IDLE.
- Masking a pending bit does not clear it. Unmasking later raises irq.

Optional Feature:
- Macro: UART_IRQ_HOLDOFF_EN.
- Defined: leaving SERVICE enters a HOLDOFF state.
  - irq = 0 and a counter loads HOLDOFF_CYCLES-1 and decrements to 0, then the FSM goes to IDLE.
  - New pending bits still latch during HOLDOFF.
  - Counter width is $clog2(HOLDOFF_CYCLES)+1.
- Undefined: no HOLDOFF state and no counter; SERVICE goes directly to IDLE.

Decomposition:
- Package uart_irq_pkg holds:
  - Address constants: ADDR_PEND, ADDR_MASK, ADDR_RAW, ADDR_ID.
  - Bit index constants: FE, CRCE, ORE, NF, TXI, TBNF, DR.
  - FSM state typedef (enum logic [1:0]: IDLE, ASSERT, SERVICE, HOLDOFF).
- One sub-module, uart_irq_prio: combinational 8-to-3 lowest-index priority encoder with a valid output.

Test Plan:
1. Reset asserted while stat_in = 8'h40 → after reset release, PEND = 8'h40 on the first cycle. With MASK = 0, irq stays 0.
2. Write MASK = 8'h7F, then pulse stat_in[2] → irq = 1 two cycles after the edge. ID read returns 8'h82 with cpu_rvalid one cycle after cpu_rd. irq drops after the ID read.
3. PEND = 8'h42 with both bits enabled → ID = 8'h81. Write PEND = 8'h02 → irq re-asserts and ID = 8'h86.
4. W1C of bit 6 in the same cycle as a new stat_in[6] rising edge → bit 6 stays set.
5. Mask the pending bit while in ASSERT → irq = 0 next cycle and PEND unchanged. Unmask → irq = 1.
6. With UART_IRQ_HOLDOFF_EN and HOLDOFF_CYCLES = 4: service, then new event during holdoff → irq stays low exactly 4 cycles after the PEND write, then asserts.
